// File: rtl/cnt5_pkg.sv
// Shared definitions for the mod-5 counter stage and its monitor.
package cnt5_pkg;

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = 3'd4;

  // Monitor FSM states
  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } mon_state_e;

endpackage

// File: rtl/cnt5_next.sv
// Next value of a mod-5 up/down counter; shared by the counter stage and the monitor.
module cnt5_next
  import cnt5_pkg::*;
(
  input  logic [CNT_W-1:0] cur,
  input  logic             inc,
  output logic [CNT_W-1:0] nxt
);

  // Up: 4 wraps to 0; down: 0 wraps to 4; otherwise step by one.
  always_comb begin
    nxt = cur;
    if (inc) begin
      nxt = (cur == CNT_MAX) ? '0 : cur + 1'b1;
    end else begin
      nxt = (cur == '0) ? CNT_MAX : cur - 1'b1;
    end
  end

endmodule

// File: rtl/cnt5_monitor.sv
// Watches a mod-5 up/down counter: reports wraps, keeps a saturating signed
// revolution count and latches illegal-step / out-of-range errors.
module cnt5_monitor
  import cnt5_pkg::*;
#(
  parameter int unsigned REV_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CNT_W-1:0]        cnt,
  input  logic                    inc,
  input  logic                    clr,
  output logic                    wrap_up,
  output logic                    wrap_dn,
  output logic signed [REV_W-1:0] rev,
  output logic                    step_err,
  output logic                    range_err,
  output logic                    fault
);

  localparam logic signed [REV_W-1:0] REV_MAX = {1'b0, {(REV_W-1){1'b1}}};
  localparam logic signed [REV_W-1:0] REV_MIN = {1'b1, {(REV_W-1){1'b0}}};
  localparam logic signed [REV_W-1:0] REV_ONE = {{(REV_W-1){1'b0}}, 1'b1};

  mon_state_e              r_state;
  logic [CNT_W-1:0]        r_prev_cnt;
  logic                    r_prev_inc;
  logic signed [REV_W-1:0] r_rev;
  logic                    r_wrap_up;
  logic                    r_wrap_dn;
  logic                    r_step_err;
  logic                    r_range_err;
  logic                    r_fault;

  logic [CNT_W-1:0]        w_expected;
  logic                    w_range_bad;
  logic                    w_step_bad;
  logic                    w_wrap_up_ev;
  logic                    w_wrap_dn_ev;
  logic signed [REV_W-1:0] w_rev_up;
  logic signed [REV_W-1:0] w_rev_dn;

  cnt5_next u_next (
    .cur (r_prev_cnt),
    .inc (r_prev_inc),
    .nxt (w_expected)
  );

  // Classify the current sample against the previous one and precompute saturated rev.
  always_comb begin
    w_range_bad  = (cnt > CNT_MAX);
    w_step_bad   = (cnt != w_expected);
    w_wrap_up_ev = r_prev_inc && (r_prev_cnt == CNT_MAX) && (cnt == '0);
    w_wrap_dn_ev = !r_prev_inc && (r_prev_cnt == '0) && (cnt == CNT_MAX);
    w_rev_up     = (r_rev == REV_MAX) ? r_rev : r_rev + REV_ONE;
    w_rev_dn     = (r_rev == REV_MIN) ? r_rev : r_rev - REV_ONE;
  end

  // Monitor FSM with registered outputs; clr overrides everything else.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= INIT;
      r_prev_cnt  <= '0;
      r_prev_inc  <= 1'b0;
      r_rev       <= '0;
      r_wrap_up   <= 1'b0;
      r_wrap_dn   <= 1'b0;
      r_step_err  <= 1'b0;
      r_range_err <= 1'b0;
      r_fault     <= 1'b0;
    end else if (clr) begin
      r_state     <= INIT;
      r_prev_cnt  <= '0;
      r_prev_inc  <= 1'b0;
      r_rev       <= '0;
      r_wrap_up   <= 1'b0;
      r_wrap_dn   <= 1'b0;
      r_step_err  <= 1'b0;
      r_range_err <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_prev_cnt <= cnt;
      r_prev_inc <= inc;
      r_wrap_up  <= 1'b0;
      r_wrap_dn  <= 1'b0;
      case (r_state)
        // First sample after reset/clr only seeds the history.
        INIT: begin
          if (w_range_bad) begin
            r_range_err <= 1'b1;
            r_fault     <= 1'b1;
            r_state     <= FAULT;
          end else begin
            r_state <= TRACK;
          end
        end
        TRACK: begin
          // Range error masks a coincident step error.
          if (w_range_bad) begin
            r_range_err <= 1'b1;
            r_fault     <= 1'b1;
            r_state     <= FAULT;
          end else if (w_step_bad) begin
            r_step_err <= 1'b1;
            r_fault    <= 1'b1;
            r_state    <= FAULT;
          end else if (w_wrap_up_ev) begin
            r_wrap_up <= 1'b1;
            r_rev     <= w_rev_up;
          end else if (w_wrap_dn_ev) begin
            r_wrap_dn <= 1'b1;
            r_rev     <= w_rev_dn;
          end
        end
        // Stuck here until clr/reset; rev frozen, no pulses.
        FAULT: begin
          if (w_range_bad) begin
            r_range_err <= 1'b1;
          end
        end
        default: begin
          r_state <= INIT;
        end
      endcase
    end
  end

  assign wrap_up   = r_wrap_up;
  assign wrap_dn   = r_wrap_dn;
  assign rev       = r_rev;
  assign step_err  = r_step_err;
  assign range_err = r_range_err;
  assign fault     = r_fault;

endmodule

// File: tb/tb_cnt5_monitor.sv
// Directed bench: a mod-5 counter stage (with load for fault injection) drives
// two monitors, REV_W=8 and REV_W=4.
module tb_cnt5_monitor;

  logic              clk;
  logic              reset_n;
  logic              inc;
  logic              clr;
  logic              clr4;
  logic              ld;
  logic [2:0]        ld_val;
  logic [2:0]        ctr;
  logic [2:0]        ctr_nxt;

  logic              wrap_up, wrap_dn, step_err, range_err, fault;
  logic signed [7:0] rev;
  logic              wrap_up4, wrap_dn4, step_err4, range_err4, fault4;
  logic signed [3:0] rev4;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cnt5_next u_ctr_next (
    .cur (ctr),
    .inc (inc),
    .nxt (ctr_nxt)
  );

  // Counter stage under observation; ld forces an arbitrary value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  ctr <= '0;
    else if (ld)   ctr <= ld_val;
    else           ctr <= ctr_nxt;
  end

  cnt5_monitor #(.REV_W(8)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cnt       (ctr),
    .inc       (inc),
    .clr       (clr),
    .wrap_up   (wrap_up),
    .wrap_dn   (wrap_dn),
    .rev       (rev),
    .step_err  (step_err),
    .range_err (range_err),
    .fault     (fault)
  );

  cnt5_monitor #(.REV_W(4)) u_dut4 (
    .clk       (clk),
    .reset_n   (reset_n),
    .cnt       (ctr),
    .inc       (inc),
    .clr       (clr | clr4),
    .wrap_up   (wrap_up4),
    .wrap_dn   (wrap_dn4),
    .rev       (rev4),
    .step_err  (step_err4),
    .range_err (range_err4),
    .fault     (fault4)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
  endtask

  // One clock: inputs set before the call take effect at the rising edge.
  task automatic step();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b1;
    inc     = 1'b1;
    clr     = 1'b0;
    clr4    = 1'b0;
    ld      = 1'b0;
    ld_val  = '0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_rev", rev, 0);
    check("rst_wrap_up", wrap_up, 0);
    check("rst_wrap_dn", wrap_dn, 0);
    check("rst_step_err", step_err, 0);
    check("rst_range_err", range_err, 0);
    check("rst_fault", fault, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Count up 12 cycles: wraps reported at edges 6 and 11.
    for (int k = 0; k < 12; k++) begin
      step();
      check("up_wrap_up", wrap_up, (edge_n == 6 || edge_n == 11) ? 1 : 0);
      check("up_wrap_dn", wrap_dn, 0);
    end
    check("up_rev", rev, 2);
    check("up_step_err", step_err, 0);
    check("up_range_err", range_err, 0);
    check("up_fault", fault, 0);

    // Reach cnt=0, then reverse direction.
    repeat (3) step();
    inc = 1'b0;
    step();
    check("rev_wrap_up16", wrap_up, 1);
    check("rev_rev16", rev, 3);
    step();
    check("dn_wrap_dn", wrap_dn, 1);
    check("dn_wrap_up", wrap_up, 0);
    check("dn_rev", rev, 2);
    check("dn_step_err", step_err, 0);
    inc = 1'b1;
    step();
    check("dn_pulse_len", wrap_dn, 0);
    check("dn_step_err2", step_err, 0);
    repeat (2) step();
    check("up2_wrap_up", wrap_up, 1);
    check("up2_rev", rev, 3);
    step();

    // Illegal step 2 -> 4.
    ld = 1'b1; ld_val = 3'd4;
    step();
    ld = 1'b0;
    check("pre_step_err", step_err, 0);
    step();
    check("step_step_err", step_err, 1);
    check("step_fault", fault, 1);
    check("step_range_err", range_err, 0);
    check("step_rev", rev, 3);
    for (int k = 0; k < 6; k++) begin
      step();
      check("flt_wrap_up", wrap_up, 0);
      check("flt_rev", rev, 3);
      check("flt_fault", fault, 1);
    end

    // Clear and resume tracking.
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_rev", rev, 0);
    check("clr_step_err", step_err, 0);
    check("clr_fault", fault, 0);
    check("clr_wrap_up", wrap_up, 0);
    repeat (3) step();
    check("res_no_wrap", wrap_up, 0);
    step();
    check("res_wrap_up", wrap_up, 1);
    check("res_rev", rev, 1);
    check("res_step_err", step_err, 0);
    check("res_fault", fault, 0);

    // Out-of-range value 6.
    ld = 1'b1; ld_val = 3'd6;
    step();
    ld = 1'b0;
    step();
    check("rng_range_err", range_err, 1);
    check("rng_step_err", step_err, 0);
    check("rng_fault", fault, 1);
    check("rng_rev", rev, 1);
    step();
    check("rng_sticky", range_err, 1);

    clr = 1'b1; ld = 1'b1; ld_val = 3'd0;
    step();
    clr = 1'b0; ld = 1'b0;
    check("clr2_range_err", range_err, 0);
    check("clr2_fault", fault, 0);
    check("clr2_rev4", rev4, 0);

    // Nine wraps on the 4-bit monitor: saturates at +7.
    while (edge_n < 88) begin
      step();
      if (edge_n == 74 || edge_n == 79 || edge_n == 84) check("sat_rev4", rev4, 7);
      if (edge_n == 84) begin
        check("sat_wrap_up4", wrap_up4, 1);
        check("sat_rev8", rev, 9);
      end
    end

    // clr on the cycle a wrap is reported: no pulse, rev cleared.
    clr4 = 1'b1;
    step();
    clr4 = 1'b0;
    check("clrwrap_wrap_up4", wrap_up4, 0);
    check("clrwrap_rev4", rev4, 0);
    check("clrwrap_wrap_up8", wrap_up, 1);
    check("clrwrap_rev8", rev, 10);
    check("clrwrap_err4", step_err4 | range_err4 | fault4 | wrap_dn4, 0);

    // Asynchronous reset between edges.
    #2 reset_n = 1'b0;
    #1;
    check("async_rev", rev, 0);
    check("async_wrap_up", wrap_up, 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cnt5_monitor.md
CNT5_MONITOR -- requirements
Module: cnt5_monitor

Interface
REQ-001 Parameter REV_W, default 8: width of the signed revolution count.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cnt  input  3  count value from the mod-5 counter stage, sampled each clk.
REQ-005 inc  input  1  direction driven into the counter stage (1 = up, 0 = down), sampled each clk.
REQ-006 clr  input  1  synchronous clear of all monitor state.
REQ-007 wrap_up  output  1  one-cycle pulse: up-wrap 4->0 seen.
REQ-008 wrap_dn  output  1  one-cycle pulse: down-wrap 0->4 seen.
REQ-009 rev  output  REV_W  signed net revolutions (up-wraps minus down-wraps).
REQ-010 step_err  output  1  sticky: illegal step seen.
REQ-011 range_err  output  1  sticky: cnt value 5..7 seen.
REQ-012 fault  output  1  high while the FSM is in FAULT.

Function
REQ-013 The block SHALL hold prev_cnt and prev_inc registers, loaded from cnt and inc on every clk edge when not in reset and clr=0.
REQ-014 expected SHALL be: prev_inc=1 -> (prev_cnt==4 ? 0 : prev_cnt+1); prev_inc=0 -> (prev_cnt==0 ? 4 : prev_cnt-1).
REQ-015 The FSM SHALL have states INIT, TRACK, FAULT; reset and clr enter INIT.
REQ-016 INIT: the next edge SHALL load prev and go to TRACK if cnt<=4, else FAULT with range_err set; no step check and no wrap in INIT.
REQ-017 TRACK: cnt>4 SHALL set range_err and go to FAULT; else cnt!=expected SHALL set step_err and go to FAULT; else stay in TRACK.
REQ-018 TRACK with prev_cnt=4, cnt=0, prev_inc=1 SHALL pulse wrap_up for exactly one cycle and increment rev.
REQ-019 TRACK with prev_cnt=0, cnt=4, prev_inc=0 SHALL pulse wrap_dn for exactly one cycle and decrement rev.
REQ-020 rev SHALL saturate at +(2^(REV_W-1)-1) and -(2^(REV_W-1)); never wrap.
REQ-021 FAULT SHALL be left only via clr or reset; in FAULT rev is frozen, wrap pulses are suppressed, and err flags keep accumulating (range_err may still set).
REQ-022 All outputs SHALL be registered; a counter transition at edge k is reported at edge k+1 (one-cycle latency).
REQ-023 clr SHALL take priority over every other event in the same cycle: flags, pulses, rev to 0, state to INIT.
REQ-024 If step_err and range_err conditions coincide, only range_err SHALL be set.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state=INIT, prev_cnt=0, prev_inc=0, rev=0, wrap_up=0, wrap_dn=0, step_err=0, range_err=0, fault=0.
REQ-026 Reset deassertion SHALL be treated like clr: the first post-reset edge is an INIT sample.
REQ-027 The counter stage is reset by the same reset_n; if that stage alone is reset mid-run, the resulting jump to 0 SHALL be reported as step_err (unless legal).

Structure
REQ-028 Shared package cnt5_pkg SHALL hold CNT_W=3, CNT_MAX=4 and the monitor state enum (INIT/TRACK/FAULT).
REQ-029 Expected-next computation SHALL be a combinational sub-module cnt5_next (inputs cur, inc; output nxt), reusable by the counter stage.
REQ-030 Target size: 120-400 RTL lines including cnt5_next.

Verification
REQ-031 Bench SHALL instantiate the mod-5 counter stage driving cnt, with shared clk (10 ns period) and reset_n.
REQ-032 Reset 10 ns, inc=1 for 12 cycles -> two wrap_up pulses, one cycle after each 4->0; rev=2; no errors.
REQ-033 inc=0 from cnt=0 -> wrap_dn one cycle after 0->4; rev decrements by 1; step_err stays 0 on the direction change.
REQ-034 Force cnt from 2 to 4 with inc=1 -> step_err=1, fault=1, rev frozen; later wraps give no pulses; clr -> all 0, INIT, tracking resumes.
REQ-035 Force cnt=6 -> range_err=1 (step_err stays 0), fault=1.
REQ-036 REV_W=4: 9 up-wraps -> rev=7 (saturated); clr asserted on the cycle a wrap is reported -> no pulse, rev=0.
